// File: rtl/pipe_mem_arbiter.sv
// Arbitrates instruction-fetch and data-memory requests onto one single-port memory.
// DM has priority; IF wins after two consecutive DM grants that it had to wait through.
module pipe_mem_arbiter #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic [31:0] dm_rdata,
    output logic        dm_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall_if,
    output logic        stall_mem,
    output logic        err,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2,
        RESP    = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    state_t      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [1:0]  starve_q, starve_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        dm_ready_q, dm_ready_d;
    logic        err_q, err_d;
    logic        if_wins;

    // Handshake: a requester holds x_req and its payload until the one-cycle
    // x_ready pulse; the cycle carrying x_ready is the only cycle x_rdata is fresh.
    assign if_wins = if_req && (starve_q == 2'd2);

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        starve_d    = starve_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        if_ready_d  = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        dm_ready_d  = 1'b0;
        err_d       = err_q;

        if (!if_req) begin
            starve_d = 2'd0;
        end

        case (state_q)
            IDLE: begin
                wait_d = 4'd0;
                if (dm_req && !if_wins) begin
                    state_d     = BUSY_DM;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    mem_be_d    = dm_be;
                    if (if_req) begin
                        starve_d = starve_q + 2'd1;
                    end
                end else if (if_req) begin
                    state_d    = BUSY_IF;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    mem_be_d   = 4'hF;
                    starve_d   = 2'd0;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack) begin
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = mem_rdata;
                        if_ready_d = 1'b1;
                    end else begin
                        dm_rdata_d = mem_rdata;
                        dm_ready_d = 1'b1;
                    end
                end else if (wait_q + 4'd1 == WAIT_LIMIT) begin
                    // Timeout: complete the access with zero data and latch the error.
                    state_d   = RESP;
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    if (state_q == BUSY_IF) begin
                        if_rdata_d = 32'd0;
                        if_ready_d = 1'b1;
                    end else begin
                        dm_rdata_d = 32'd0;
                        dm_ready_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= IDLE;
            wait_q      <= 4'd0;
            starve_q    <= 2'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            mem_be_q    <= 4'd0;
            if_rdata_q  <= 32'd0;
            if_ready_q  <= 1'b0;
            dm_rdata_q  <= 32'd0;
            dm_ready_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            starve_q    <= starve_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            if_ready_q  <= if_ready_d;
            dm_rdata_q  <= dm_rdata_d;
            dm_ready_q  <= dm_ready_d;
            err_q       <= err_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign if_ready  = if_ready_q;
    assign dm_rdata  = dm_rdata_q;
    assign dm_ready  = dm_ready_q;
    assign err       = err_q;
    assign state_dbg = state_q;
    assign stall_if  = if_req & ~if_ready_q;
    assign stall_mem = dm_req & ~dm_ready_q;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed bench for pipe_mem_arbiter: fetch, priority, anti-starvation,
// timeout abort and mid-transaction reset, with hand-computed expectations.
module tb_pipe_mem_arbiter;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_BUSY_IF = 2'd1;
    localparam logic [1:0] S_BUSY_DM = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    logic        clk;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_be;
    logic [31:0] dm_rdata;
    logic        dm_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        stall_if;
    logic        stall_mem;
    logic        err;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    pipe_mem_arbiter #(.MAX_WAIT(15)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_ready  (if_ready),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_be     (dm_be),
        .dm_rdata  (dm_rdata),
        .dm_ready  (dm_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .stall_if  (stall_if),
        .stall_mem (stall_mem),
        .err       (err),
        .state_dbg (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_state"},  32'(state_dbg), 32'(S_IDLE));
        chk({tag, "_mreq"},   32'(mem_req),   32'd0);
        chk({tag, "_mwe"},    32'(mem_we),    32'd0);
        chk({tag, "_maddr"},  mem_addr,       32'd0);
        chk({tag, "_mwdata"}, mem_wdata,      32'd0);
        chk({tag, "_mbe"},    32'(mem_be),    32'd0);
        chk({tag, "_ifrdy"},  32'(if_ready),  32'd0);
        chk({tag, "_dmrdy"},  32'(dm_ready),  32'd0);
        chk({tag, "_ifrd"},   if_rdata,       32'd0);
        chk({tag, "_dmrd"},   dm_rdata,       32'd0);
        chk({tag, "_err"},    32'(err),       32'd0);
    endtask

    initial begin
        rstn = 1'b0; if_req = 1'b0; if_addr = 32'd0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 32'd0; dm_wdata = 32'd0; dm_be = 4'd0;
        mem_rdata = 32'd0; mem_ack = 1'b0;
        tick();
        tick();
        chk_reset_state("rst");
        rstn = 1'b1;
        tick();

        // Single fetch with ack one cycle after mem_req.
        if_req = 1'b1; if_addr = 32'h0000_0040;
        #1;
        chk("fetch_stall_pre", 32'(stall_if), 32'd1);
        tick();
        chk("fetch_state",  32'(state_dbg), 32'(S_BUSY_IF));
        chk("fetch_mreq",   32'(mem_req),   32'd1);
        chk("fetch_maddr",  mem_addr,       32'h0000_0040);
        chk("fetch_mwe",    32'(mem_we),    32'd0);
        chk("fetch_mbe",    32'(mem_be),    32'hF);
        chk("fetch_rdy_early", 32'(if_ready), 32'd0);
        chk("fetch_stall",  32'(stall_if),  32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h0080_0093;
        tick();
        chk("fetch_rdy",    32'(if_ready),  32'd1);
        chk("fetch_rdata",  if_rdata,       32'h0080_0093);
        chk("fetch_mreq_off", 32'(mem_req), 32'd0);
        chk("fetch_stall_off", 32'(stall_if), 32'd0);
        chk("fetch_resp",   32'(state_dbg), 32'(S_RESP));
        mem_ack = 1'b0; if_req = 1'b0; mem_rdata = 32'h5555_5555;
        tick();
        chk("fetch_rdy_pulse", 32'(if_ready), 32'd0);
        chk("fetch_rdata_hold", if_rdata, 32'h0080_0093);
        chk("fetch_idle", 32'(state_dbg), 32'(S_IDLE));

        // Both requests together: DM write first, then IF.
        if_req = 1'b1; if_addr = 32'h0000_0044;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0100; dm_wdata = 32'hDEAD_BEEF; dm_be = 4'b0011;
        tick();
        chk("both_state",  32'(state_dbg), 32'(S_BUSY_DM));
        chk("both_mwe",    32'(mem_we),    32'd1);
        chk("both_maddr",  mem_addr,       32'h0000_0100);
        chk("both_mwdata", mem_wdata,      32'hDEAD_BEEF);
        chk("both_mbe",    32'(mem_be),    32'b0011);
        chk("both_stall_mem", 32'(stall_mem), 32'd1);
        chk("both_stall_if",  32'(stall_if),  32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        tick();
        chk("both_dmrdy",  32'(dm_ready), 32'd1);
        chk("both_dmrd",   dm_rdata,      32'h1111_1111);
        chk("both_ifrdy",  32'(if_ready), 32'd0);
        mem_ack = 1'b0; dm_req = 1'b0;
        tick();
        chk("both_idle", 32'(state_dbg), 32'(S_IDLE));
        tick();
        chk("both_if_state", 32'(state_dbg), 32'(S_BUSY_IF));
        chk("both_if_maddr", mem_addr,       32'h0000_0044);
        chk("both_if_mwe",   32'(mem_we),    32'd0);
        chk("both_if_mbe",   32'(mem_be),    32'hF);
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222;
        tick();
        chk("both_if_rdy",   32'(if_ready), 32'd1);
        chk("both_if_rd",    if_rdata,      32'h2222_2222);
        mem_ack = 1'b0; if_req = 1'b0;
        tick();

        // Anti-starvation: dm_req held over back-to-back loads with if_req high.
        if_req = 1'b1; if_addr = 32'h0000_0080;
        dm_req = 1'b1; dm_we = 1'b0; dm_be = 4'hF;
        for (int k = 0; k < 4; k++) begin
            dm_addr = 32'h0000_0200 + 32'(k);
            tick();
            chk($sformatf("starve%0d_state", k), 32'(state_dbg),
                32'((k == 2) ? S_BUSY_IF : S_BUSY_DM));
            chk($sformatf("starve%0d_maddr", k), mem_addr,
                (k == 2) ? 32'h0000_0080 : 32'h0000_0200 + 32'(k));
            mem_ack = 1'b1; mem_rdata = 32'h0000_1000 + 32'(k);
            tick();
            if (k == 2) begin
                chk("starve2_ifrdy", 32'(if_ready), 32'd1);
                chk("starve2_ifrd",  if_rdata,      32'h0000_1002);
                chk("starve2_dmrdy", 32'(dm_ready), 32'd0);
            end else begin
                chk($sformatf("starve%0d_dmrdy", k), 32'(dm_ready), 32'd1);
                chk($sformatf("starve%0d_dmrd", k),  dm_rdata, 32'h0000_1000 + 32'(k));
                chk($sformatf("starve%0d_ifrdy", k), 32'(if_ready), 32'd0);
            end
            mem_ack = 1'b0;
            tick();
        end
        dm_req = 1'b0; if_req = 1'b0;
        tick();

        // Timeout: no ack for 15 cycles after the grant.
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300;
        tick();
        chk("to_state", 32'(state_dbg), 32'(S_BUSY_DM));
        for (int i = 1; i < 15; i++) begin
            tick();
            if (i == 1 || i == 14) begin
                chk($sformatf("to_busy%0d", i), 32'(state_dbg), 32'(S_BUSY_DM));
                chk($sformatf("to_mreq%0d", i), 32'(mem_req),   32'd1);
                chk($sformatf("to_rdy%0d", i),  32'(dm_ready),  32'd0);
            end
        end
        tick();
        chk("to_dmrdy", 32'(dm_ready), 32'd1);
        chk("to_dmrd",  dm_rdata,      32'd0);
        chk("to_err",   32'(err),      32'd1);
        chk("to_mreq",  32'(mem_req),  32'd0);
        dm_req = 1'b0;
        tick();
        chk("to_idle",      32'(state_dbg), 32'(S_IDLE));
        chk("to_err_stick", 32'(err),       32'd1);
        tick();
        chk("to_err_stick2", 32'(err), 32'd1);

        // Reset in the middle of a DM access, then a stale ack.
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0400; dm_wdata = 32'hCAFE_F00D; dm_be = 4'hC;
        tick();
        chk("mr_state", 32'(state_dbg), 32'(S_BUSY_DM));
        tick();
        rstn = 1'b0;
        tick();
        chk_reset_state("mr");
        dm_req = 1'b0; rstn = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
        tick();
        chk("mr_stale_dmrdy", 32'(dm_ready),  32'd0);
        chk("mr_stale_state", 32'(state_dbg), 32'(S_IDLE));
        chk("mr_stale_dmrd",  dm_rdata,       32'd0);
        tick();
        chk("mr_stale_dmrdy2", 32'(dm_ready), 32'd0);
        mem_ack = 1'b0;

        // Fetch after reset; requester drops if_req while busy, access still completes.
        if_req = 1'b1; if_addr = 32'h0000_0500;
        tick();
        chk("post_state", 32'(state_dbg), 32'(S_BUSY_IF));
        chk("post_maddr", mem_addr,       32'h0000_0500);
        if_req = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h0000_0044;
        tick();
        chk("post_ifrdy", 32'(if_ready), 32'd1);
        chk("post_ifrd",  if_rdata,      32'h0000_0044);
        chk("post_err",   32'(err),      32'd0);
        mem_ack = 1'b0;
        tick();
        chk("post_idle",  32'(state_dbg), 32'(S_IDLE));
        chk("post_rdy_off", 32'(if_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
